// File: rtl/result_requant_packer.sv
// Requantizes a signed accumulator stream (round, shift, saturate) and packs
// PACK lanes per output word, with frame-end tlast and a 2-deep output FIFO.
module result_requant_packer #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int PACK      = 4,
    parameter int SHIFT     = 8,
    parameter int FRAME_LEN = 128
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [ACC_WIDTH-1:0]      s_axis_results_tdata,
    input  logic                      s_axis_results_tvalid,
    output logic                      s_axis_results_tready,
    output logic [OUT_WIDTH*PACK-1:0] m_axis_out_tdata,
    output logic                      m_axis_out_tvalid,
    input  logic                      m_axis_out_tready,
    output logic                      m_axis_out_tlast,
    output logic [15:0]               sat_count
);

    localparam int EXT      = ACC_WIDTH + 1;
    localparam int LW       = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int BW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DW       = OUT_WIDTH * PACK;
    localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EXT-1:0] BIAS  = (SHIFT > 0) ? (EXT'(1) << SHIFT_M1) : '0;
    localparam logic signed [EXT-1:0] MAX_V = {{(EXT-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT-1:0] MIN_V = {{(EXT-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Handshake: a beat moves when valid & ready are both high at a rising
    // edge; valid never waits on ready, and output data/last hold while
    // valid is high until the beat moves.

    logic                        accept;
    logic                        push;
    logic                        pop;
    logic                        word_done;
    logic                        last_beat;

    logic signed [EXT-1:0]       x_ext;
    logic signed [EXT-1:0]       sum;
    logic signed [EXT-1:0]       shifted;
    logic                        clip_hi;
    logic                        clip_lo;
    logic [OUT_WIDTH-1:0]        lane_val;

    logic [LW-1:0]               lane_idx;
    logic [BW-1:0]               beat_cnt;
    logic [PACK-1:0][OUT_WIDTH-1:0] pack_reg;
    logic [PACK-1:0][OUT_WIDTH-1:0] word_next;

    logic [DW:0]                 fifo_mem [2];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  fifo_count;

    assign s_axis_results_tready = (fifo_count < 2'd2);
    assign m_axis_out_tvalid     = (fifo_count != 2'd0);
    assign m_axis_out_tdata      = fifo_mem[rd_ptr][DW-1:0];
    assign m_axis_out_tlast      = fifo_mem[rd_ptr][DW];

    assign accept    = s_axis_results_tvalid & s_axis_results_tready;
    assign pop       = m_axis_out_tvalid & m_axis_out_tready;
    assign last_beat = (beat_cnt == BW'(FRAME_LEN - 1));
    assign word_done = (lane_idx == LW'(PACK - 1)) || last_beat;
    assign push      = accept & word_done;

    // One sign bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        x_ext   = {s_axis_results_tdata[ACC_WIDTH-1], s_axis_results_tdata};
        sum     = x_ext + BIAS;
        shifted = sum >>> SHIFT;
        clip_hi = (shifted > MAX_V);
        clip_lo = (shifted < MIN_V);
        if (clip_hi) begin
            lane_val = MAX_V[OUT_WIDTH-1:0];
        end else if (clip_lo) begin
            lane_val = MIN_V[OUT_WIDTH-1:0];
        end else begin
            lane_val = shifted[OUT_WIDTH-1:0];
        end
    end

    // Completed word: earlier lanes from the pack register, the current lane
    // from this beat, and everything above it zero.
    always_comb begin
        word_next = '0;
        for (int i = 0; i < PACK; i++) begin
            if (i < int'(lane_idx)) begin
                word_next[i] = pack_reg[i];
            end else if (i == int'(lane_idx)) begin
                word_next[i] = lane_val;
            end else begin
                word_next[i] = '0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            lane_idx    <= '0;
            beat_cnt    <= '0;
            pack_reg    <= '0;
            sat_count   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (accept) begin
                if ((clip_hi || clip_lo) && (sat_count != 16'hFFFF)) begin
                    sat_count <= sat_count + 16'd1;
                end
                if (word_done) begin
                    pack_reg <= '0;
                    lane_idx <= '0;
                end else begin
                    pack_reg[lane_idx] <= lane_val;
                    lane_idx           <= lane_idx + LW'(1);
                end
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            end

            if (push) begin
                fifo_mem[wr_ptr] <= {last_beat, word_next};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_requant_packer.sv
// Bench for result_requant_packer: two instances (frame 128 and frame 6) share
// stimulus; each is scored against an arithmetic model of requant and packing.
module tb_result_requant_packer;

  localparam int AW   = 32;
  localparam int OW   = 8;
  localparam int PK   = 4;
  localparam int SH   = 8;
  localparam int FL_A = 128;
  localparam int FL_B = 6;
  localparam int W    = OW * PK;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [AW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          m_tready = 1'b0;

  logic          a_s_tready, a_tvalid, a_tlast;
  logic [W-1:0]  a_tdata;
  logic [15:0]   a_sat;
  logic          b_s_tready, b_tvalid, b_tlast;
  logic [W-1:0]  b_tdata;
  logic [15:0]   b_sat;

  result_requant_packer #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .PACK(PK), .SHIFT(SH), .FRAME_LEN(FL_A)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_results_tdata(s_tdata), .s_axis_results_tvalid(s_tvalid), .s_axis_results_tready(a_s_tready),
    .m_axis_out_tdata(a_tdata), .m_axis_out_tvalid(a_tvalid), .m_axis_out_tready(m_tready),
    .m_axis_out_tlast(a_tlast), .sat_count(a_sat)
  );

  result_requant_packer #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .PACK(PK), .SHIFT(SH), .FRAME_LEN(FL_B)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_results_tdata(s_tdata), .s_axis_results_tvalid(s_tvalid), .s_axis_results_tready(b_s_tready),
    .m_axis_out_tdata(b_tdata), .m_axis_out_tvalid(b_tvalid), .m_axis_out_tready(m_tready),
    .m_axis_out_tlast(b_tlast), .sat_count(b_sat)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round half up, floor-divide by 2^SH, clamp to the signed output range.
  function automatic logic [OW-1:0] requant(input logic [AW-1:0] d, output bit clipped);
    longint div, v, r, hi, lo;
    div = longint'(1) << SH;
    hi  = (longint'(1) << (OW - 1)) - 1;
    lo  = -(longint'(1) << (OW - 1));
    v   = longint'($signed(d)) + ((SH > 0) ? div / 2 : 0);
    r   = (v >= 0) ? v / div : -((-v + div - 1) / div);
    clipped = (r > hi) || (r < lo);
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r[OW-1:0];
  endfunction

  // Scoreboard for instance a
  logic [W:0]    exp_q_a[$];
  logic [OW-1:0] buf_a[PK];
  int lane_a = 0, beat_a = 0, sat_a = 0, pops_a = 0, acc_a = 0;

  always @(negedge ap_clk) begin : mon_a
    logic [OW-1:0] lv;
    logic [W:0]    ex;
    logic [W-1:0]  wd;
    bit            clp;
    if (!ap_rst_n) begin
      exp_q_a.delete();
      lane_a = 0; beat_a = 0; sat_a = 0;
    end else begin
      check("a_valid", a_tvalid, exp_q_a.size() != 0);
      check("a_ready", a_s_tready, exp_q_a.size() < 2);
      check("a_sat", a_sat, sat_a);
      if (a_tvalid && m_tready) begin
        pops_a++;
        if (exp_q_a.size() != 0) begin
          ex = exp_q_a.pop_front();
          check("a_word", {a_tlast, a_tdata}, ex);
        end
      end
      if (s_tvalid && a_s_tready) begin
        acc_a++;
        lv = requant(s_tdata, clp);
        if (clp && sat_a < 65535) sat_a++;
        buf_a[lane_a] = lv;
        if (lane_a == PK - 1 || beat_a == FL_A - 1) begin
          wd = '0;
          for (int i = 0; i <= lane_a; i++) wd[i*OW +: OW] = buf_a[i];
          exp_q_a.push_back({beat_a == FL_A - 1, wd});
          lane_a = 0;
        end else begin
          lane_a++;
        end
        beat_a = (beat_a + 1) % FL_A;
      end
    end
  end

  // Scoreboard for instance b
  logic [W:0]    exp_q_b[$];
  logic [OW-1:0] buf_b[PK];
  int lane_b = 0, beat_b = 0, sat_b = 0;

  always @(negedge ap_clk) begin : mon_b
    logic [OW-1:0] lv;
    logic [W:0]    ex;
    logic [W-1:0]  wd;
    bit            clp;
    if (!ap_rst_n) begin
      exp_q_b.delete();
      lane_b = 0; beat_b = 0; sat_b = 0;
    end else begin
      check("b_valid", b_tvalid, exp_q_b.size() != 0);
      check("b_ready", b_s_tready, exp_q_b.size() < 2);
      check("b_sat", b_sat, sat_b);
      if (b_tvalid && m_tready && exp_q_b.size() != 0) begin
        ex = exp_q_b.pop_front();
        check("b_word", {b_tlast, b_tdata}, ex);
      end
      if (s_tvalid && b_s_tready) begin
        lv = requant(s_tdata, clp);
        if (clp && sat_b < 65535) sat_b++;
        buf_b[lane_b] = lv;
        if (lane_b == PK - 1 || beat_b == FL_B - 1) begin
          wd = '0;
          for (int i = 0; i <= lane_b; i++) wd[i*OW +: OW] = buf_b[i];
          exp_q_b.push_back({beat_b == FL_B - 1, wd});
          lane_b = 0;
        end else begin
          lane_b++;
        end
        beat_b = (beat_b + 1) % FL_B;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    s_tvalid = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
  endtask

  // Caller guarantees both instances are ready (m_tready high, FIFOs draining).
  task automatic send(input logic [AW-1:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  typedef struct packed {
    logic [PK-1:0][AW-1:0] d;
    logic [W-1:0]          word;
    logic [15:0]           sat;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int acc, first_block, p0, guard;
    logic [W-1:0] pf_words[3];
    logic         pf_last[3];
    logic [AW-1:0] r;

    vecs[0].d[0] = 32'd384;       vecs[0].d[1] = 32'h7FFFFFFF;
    vecs[0].d[2] = 32'hFFFFFFFF;  vecs[0].d[3] = 32'hFFFFFE80;
    vecs[0].word = 32'hFF007F02;  vecs[0].sat  = 16'd1;
    vecs[1].d[0] = 32'h80000000;  vecs[1].d[1] = 32'h00000080;
    vecs[1].d[2] = 32'hFFFFFF7F;  vecs[1].d[3] = 32'h00007FFF;
    vecs[1].word = 32'h7FFF0180;  vecs[1].sat  = 16'd3;
    vecs[2].d[0] = 32'h00007F7F;  vecs[2].d[1] = 32'hFFFF8000;
    vecs[2].d[2] = 32'hFFFF7F7F;  vecs[2].d[3] = 32'h00000000;
    vecs[2].word = 32'h0080807F;  vecs[2].sat  = 16'd4;

    pf_words[0] = 32'h04030201; pf_last[0] = 1'b0;
    pf_words[1] = 32'h00000605; pf_last[1] = 1'b1;
    pf_words[2] = 32'h0A090807; pf_last[2] = 1'b0;

    // Reset state
    do_reset();
    @(negedge ap_clk);
    check("rst_tvalid", a_tvalid, 1'b0);
    check("rst_tlast", a_tlast, 1'b0);
    check("rst_tdata", a_tdata, '0);
    check("rst_sat", a_sat, 16'd0);
    check("rst_tready", a_s_tready, 1'b1);
    tick();

    // Requant table: four back-to-back beats per word, valid one cycle later
    m_tready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < PK; j++) send(vecs[v].d[j]);
      @(negedge ap_clk);
      check("tbl_valid", a_tvalid, 1'b1);
      check("tbl_word", a_tdata, vecs[v].word);
      check("tbl_last", a_tlast, 1'b0);
      check("tbl_sat", a_sat, vecs[v].sat);
      tick();
    end

    // Partial frame on the FRAME_LEN=6 instance, then the next frame restarts
    do_reset();
    m_tready = 1'b1;
    p0 = 0;
    for (int k = 1; k <= 10; k++) begin
      send(AW'(256 * k));
      if (k == 4 || k == 6 || k == 10) begin
        @(negedge ap_clk);
        check("pf_valid", b_tvalid, 1'b1);
        check("pf_word", b_tdata, pf_words[p0]);
        check("pf_last", b_tlast, pf_last[p0]);
        p0++;
        tick();
      end
    end

    // Backpressure: output stalled 20 cycles with continuous input
    do_reset();
    m_tready = 1'b0;
    acc = 0;
    first_block = -1;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_tdata = $urandom;
      if (a_s_tready) acc++;
      else if (first_block < 0) first_block = acc;
      tick();
    end
    s_tvalid = 1'b0;
    check("bp_accepted", acc, 8);
    check("bp_block_at", first_block, 8);
    check("bp_tready_low", a_s_tready, 1'b0);
    p0 = pops_a;
    m_tready = 1'b1;
    repeat (6) tick();
    check("bp_drained", pops_a - p0, 2);
    check("bp_empty", a_tvalid, 1'b0);

    // Random handshakes over ten frames of the default instance
    do_reset();
    p0 = acc_a;
    guard = 0;
    while ((acc_a - p0) < 10 * FL_A && guard < 20000) begin
      r = $urandom;
      s_tdata  = $signed(r) >>> $urandom_range(0, 30);
      s_tvalid = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 2) != 0);
      guard++;
      tick();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (8) tick();
    check("rnd_progress", (acc_a - p0) >= 10 * FL_A, 1'b1);
    check("rnd_a_drained", exp_q_a.size(), 0);
    check("rnd_b_drained", exp_q_b.size(), 0);

    // Reset mid-frame with one word queued and two lanes pending
    do_reset();
    m_tready = 1'b0;
    s_tdata  = 32'h7FFFFFFF;
    s_tvalid = 1'b1;
    tick();
    for (int k = 2; k <= 6; k++) begin
      s_tdata = AW'(256 * k);
      tick();
    end
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    check("mr_pre_valid", a_tvalid, 1'b1);
    check("mr_pre_sat", a_sat, 16'd1);
    tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("mr_valid", a_tvalid, 1'b0);
    check("mr_sat", a_sat, 16'd0);
    check("mr_b_valid", b_tvalid, 1'b0);
    tick();
    m_tready = 1'b1;
    for (int k = 1; k <= 6; k++) send(AW'(256 * k));
    @(negedge ap_clk);
    check("mr_b_word", b_tdata, 32'h00000605);
    check("mr_b_last", b_tlast, 1'b1);
    tick();

    // Saturation counter holds at its ceiling
    do_reset();
    m_tready = 1'b1;
    s_tdata  = 32'h80000000;
    s_tvalid = 1'b1;
    repeat (70000) tick();
    s_tvalid = 1'b0;
    tick();
    check("sat_hold_a", a_sat, 16'hFFFF);
    check("sat_hold_b", b_sat, 16'hFFFF);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
